bus_sram_slave: RTL

BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

---
 rtl/bus_sram_slave.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM slave on a wired-OR burst bus, one byte-wide memory per lane.
// Optional BUS_SRAM_SLAVE_ERROR_EN: flag bursts that run past the top word instead of wrapping.

module bus_sram_lane #(
   parameter int AW = 8
) (
   input  logic          clock,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] mem [0:(1<<AW)-1];

   // rdata holds between reads; the top gates it with its valid flag
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end
endmodule

module bus_sram_slave #(
   parameter logic [31:0] BASE_ADDRESS    = 32'h50000000,
   parameter int          ADDR_WORDS_LOG2 = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        beginTransactionIN,
   input  logic        endTransactionIN,
   input  logic [31:0] addressDataIN,
   input  logic [3:0]  byteEnablesIN,
   input  logic [7:0]  burstSizeIN,
   input  logic        readNotWriteIN,
   input  logic        dataValidIN,
   input  logic        busyIN,
   output logic [31:0] addressDataOUT,
   output logic        dataValidOUT,
   output logic        endTransactionOUT,
   output logic        busyOUT,
   output logic        errorOUT
);
   localparam int AW        = ADDR_WORDS_LOG2;
   localparam int NUM_LANES = 4;

`ifdef BUS_SRAM_SLAVE_ERROR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_WAIT  = 3'd1;
   localparam logic [2:0] RD_BURST = 3'd2;
   localparam logic [2:0] WR_BURST = 3'd3;
   localparam logic [2:0] RD_END   = 3'd4;

   localparam logic [AW:0] IDX_ONE = 1;

   // idx carries one extra bit so a pass over the top word is visible
   typedef struct packed {
      logic [AW:0] idx;
      logic [7:0]  burst;
      logic [3:0]  be;
      logic        rnw;
   } req_t;

   logic [2:0]                      state;
   req_t                            req;
   logic [7:0]                      cnt;
   logic                            dv_q, eot_q;
   logic [NUM_LANES-1:0][7:0]       lane_rdata;
   logic                            sel, rd_adv, wr_beat, ovf, rd_en, wr_en, err_hit;

   assign sel     = beginTransactionIN &&
                    (addressDataIN[31:AW+2] == BASE_ADDRESS[31:AW+2]);
   assign rd_adv  = (state == RD_BURST) && !endTransactionIN && !busyIN && (cnt != req.burst);
   assign wr_beat = (state == WR_BURST) && !endTransactionIN && dataValidIN;
   assign ovf     = ERR_EN && req.idx[AW];
   assign rd_en   = ((state == RD_WAIT) && !endTransactionIN) || (rd_adv && !ovf);
   assign wr_en   = wr_beat && !ovf && !reset;
   assign err_hit = (rd_adv || wr_beat) && ovf;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      bus_sram_lane #(.AW(AW)) u_lane (
         .clock (clock),
         .we    (wr_en && req.be[l]),
         .re    (rd_en),
         .addr  (req.idx[AW-1:0]),
         .wdata (addressDataIN[8*l +: 8]),
         .rdata (lane_rdata[l])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         req   <= '0;
         cnt   <= '0;
         dv_q  <= 1'b0;
         eot_q <= 1'b0;
      end else begin
         eot_q <= 1'b0;
         case (state)
            IDLE: if (sel) begin
               req.idx   <= {1'b0, addressDataIN[AW+1:2]};
               req.burst <= burstSizeIN;
               req.be    <= byteEnablesIN;
               req.rnw   <= readNotWriteIN;
               cnt       <= '0;
               state     <= readNotWriteIN ? RD_WAIT : WR_BURST;
            end
            RD_WAIT: if (endTransactionIN) state <= IDLE;
            else begin
               dv_q    <= 1'b1;
               req.idx <= req.idx + IDX_ONE;
               state   <= RD_BURST;
            end
            RD_BURST: if (endTransactionIN) begin
               state <= IDLE;
               dv_q  <= 1'b0;
            end else if (!busyIN) begin
               if (cnt == req.burst) begin
                  state <= RD_END;
                  dv_q  <= 1'b0;
                  eot_q <= 1'b1;
               end else if (ovf) begin
                  state <= IDLE;
                  dv_q  <= 1'b0;
               end else begin
                  req.idx <= req.idx + IDX_ONE;
                  cnt     <= cnt + 8'd1;
               end
            end
            WR_BURST: if (endTransactionIN || (dataValidIN && ovf)) state <= IDLE;
            else if (dataValidIN) begin
               req.idx <= req.idx + IDX_ONE;
               cnt     <= cnt + 8'd1;
               if (cnt == req.burst) state <= IDLE;
            end
            RD_END:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BUS_SRAM_SLAVE_ERROR_EN
   logic err_q;
   always_ff @(posedge clock) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_hit;
   end
   assign errorOUT = err_q;
`else
   assign errorOUT = 1'b0;
`endif

   assign addressDataOUT    = dv_q ? lane_rdata : 32'h0;
   assign dataValidOUT      = dv_q;
   assign endTransactionOUT = eot_q;
   assign busyOUT           = 1'b0;
endmodule
